// File: rtl/tow_led_ctrl.sv
// tow_led_ctrl: tug-of-war rope position, win detect and LED mode; optional input lockout via TOW_LOCKOUT_EN
module tow_led_ctrl #(
  parameter int RST_HOLD  = 4,
  parameter int BLINK_DIV = 8,
  parameter int LOCK_CYC  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pbl,
  input  logic       pbr,
  output logic [6:0] score,
  output logic [1:0] led_ctrl,
  output logic [1:0] winner
);
  localparam int M1 = RST_HOLD > BLINK_DIV ? RST_HOLD : BLINK_DIV;
  localparam int CW = $clog2((M1 > LOCK_CYC ? M1 : LOCK_CYC) + 1);
  typedef enum logic [1:0] {SHOW_RST, PLAY, WIN} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic blink, pbl_q, pbr_q, push_l, push_r, mv_l, mv_r, lock;
  assign push_l = pbl & ~pbl_q;
  assign push_r = pbr & ~pbr_q;
`ifdef TOW_LOCKOUT_EN
  assign lock = state == PLAY && cnt != '0;
`else
  assign lock = 1'b0;
`endif
  assign mv_l = state == PLAY && push_l && !push_r && !lock;
  assign mv_r = state == PLAY && push_r && !push_l && !lock;
  always_ff @(posedge clk)
    if (rst) state <= SHOW_RST;
    else     state <= state_n;
  always_comb begin
    state_n = state;
    if (state == SHOW_RST) state_n = cnt == CW'(RST_HOLD - 1) ? PLAY : SHOW_RST;
    else if (state == PLAY) state_n = (mv_l && score[5]) || (mv_r && score[1]) ? WIN : PLAY;
  end
  always_ff @(posedge clk)
    if (rst) begin
      score  <= 7'b0001000;
      winner <= 2'b00;
      cnt    <= '0;
      blink  <= 1'b0;
      pbl_q  <= 1'b1;
      pbr_q  <= 1'b1;
    end else begin
      pbl_q <= pbl;
      pbr_q <= pbr;
      if (state == SHOW_RST) cnt <= state_n == PLAY ? '0 : cnt + 1'b1;
      else if (state == WIN) begin
        cnt   <= cnt == CW'(BLINK_DIV - 1) ? '0 : cnt + 1'b1;
        blink <= cnt == CW'(BLINK_DIV - 1) ? ~blink : blink;
      end else begin
        score  <= mv_l ? score << 1 : mv_r ? score >> 1 : score;
        winner <= (mv_l && score[5]) ? 2'b10 : (mv_r && score[1]) ? 2'b01 : winner;
`ifdef TOW_LOCKOUT_EN
        // lockout counts down from the move edge; balanced pushes never load it
        cnt <= state_n == WIN ? '0 : (mv_l || mv_r) ? CW'(LOCK_CYC) : lock ? cnt - 1'b1 : cnt;
`else
        cnt <= '0;
`endif
      end
    end
  always_comb led_ctrl = state == SHOW_RST ? 2'b11 : (state == WIN && blink) ? 2'b00 : 2'b10;
endmodule
